// File: rtl/ant_pow_scan.sv
// Antenna-power scan controller: walks the 16:1 selector and reports the strongest antenna.
// Optional build macro ANT_POW_SCAN_SUM_EN adds the sum_pow output (sum of all 16 powers).
module ant_pow_scan #(
  parameter int PW      = 32,
  parameter int MUX_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic [3:0]    ant_posinfo,
  input  logic [PW-1:0] ant_pow,
  output logic          done,
  output logic [PW-1:0] max_pow,
  output logic [3:0]    max_idx
`ifdef ANT_POW_SCAN_SUM_EN
  ,
  output logic [PW+3:0] sum_pow
`endif
);

  // state   | meaning
  // S_IDLE  | waiting for start, ant_posinfo held at 0
  // S_ISSUE | driving antenna indices 0..15, one per cycle
  // S_DRAIN | waiting MUX_LAT cycles for the last samples to return
  // S_DONE  | one-cycle done pulse, results just updated
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  localparam logic [1:0] DRAIN_LOAD = 2'(MUX_LAT - 1);

  state_t              state, state_nxt;
  logic   [3:0]        idx;
  logic   [1:0]        tmr_drain;
  logic   [MUX_LAT-1:0] pv;
  logic   [3:0]        pidx [MUX_LAT];
  logic                samp_v;
  logic   [3:0]        samp_idx;
  logic   [PW-1:0]     run_pow, run_pow_nxt;
  logic   [3:0]        run_idx, run_idx_nxt;
  logic                enter_done;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    busy        = 1'b0;
    done        = 1'b0;
    ant_posinfo = 4'd0;
    case (state)
      S_IDLE:  if (start) state_nxt = S_ISSUE;
      S_ISSUE: begin
        busy        = 1'b1;
        ant_posinfo = idx;
        if (idx == 4'd15) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (tmr_drain == 2'd0) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign enter_done = (state == S_DRAIN) && (tmr_drain == 2'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      idx       <= 4'd0;
      tmr_drain <= 2'd0;
    end else begin
      idx <= (state == S_ISSUE) ? idx + 4'd1 : 4'd0;
      if (state == S_ISSUE)
        tmr_drain <= DRAIN_LOAD;
      else if (state == S_DRAIN && tmr_drain != 2'd0)
        tmr_drain <= tmr_drain - 2'd1;
    end
  end

  // Delay line pairing each issued index with the power that returns MUX_LAT cycles later.
  always_ff @(posedge clk) begin
    if (rst) begin
      pv <= '0;
    end else begin
      pv[0] <= (state == S_ISSUE);
      for (int i = 1; i < MUX_LAT; i++) pv[i] <= pv[i-1];
    end
  end

  always_ff @(posedge clk) begin
    pidx[0] <= idx;
    for (int i = 1; i < MUX_LAT; i++) pidx[i] <= pidx[i-1];
  end

  assign samp_v   = pv[MUX_LAT-1];
  assign samp_idx = pidx[MUX_LAT-1];

  // Index 0 seeds the maximum; strict compare afterwards keeps the lowest index on ties.
  always_comb begin
    run_pow_nxt = run_pow;
    run_idx_nxt = run_idx;
    if (samp_v && (samp_idx == 4'd0 || ant_pow > run_pow)) begin
      run_pow_nxt = ant_pow;
      run_idx_nxt = samp_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_pow <= '0;
      run_idx <= 4'd0;
      max_pow <= '0;
      max_idx <= 4'd0;
    end else begin
      run_pow <= run_pow_nxt;
      run_idx <= run_idx_nxt;
      if (enter_done) begin
        max_pow <= run_pow_nxt;
        max_idx <= run_idx_nxt;
      end
    end
  end

`ifdef ANT_POW_SCAN_SUM_EN
  logic [PW+3:0] sum_acc, sum_nxt;

  assign sum_nxt = sum_acc + (samp_v ? {4'b0, ant_pow} : '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_acc <= '0;
      sum_pow <= '0;
    end else begin
      if (state == S_IDLE && start) sum_acc <= '0;
      else                          sum_acc <= sum_nxt;
      if (enter_done) sum_pow <= sum_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_ant_pow_scan.sv
// Scoreboard bench for ant_pow_scan: two instances (MUX_LAT=1 and 3) share stimulus;
// a scan-level reference model predicts timing and results, a negedge monitor checks.
module tb_ant_pow_scan;
  localparam int PW = 32;
  localparam int NL = 2;

  typedef struct {
    int              lane;
    int              epoch;
    int              tdone;
    logic [PW-1:0]   mx;
    logic [3:0]      ix;
    logic [PW+3:0]   sm;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [PW-1:0] pow_tab [16];

  logic [NL-1:0]          busy_v, done_v;
  logic [NL-1:0][3:0]     pos_v, midx_v;
  logic [NL-1:0][PW-1:0]  mpow_v;
  logic [NL-1:0][PW+3:0]  sum_v;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NL; g++) begin : g_lane
    localparam int LAT = (g == 0) ? 1 : 3;
    logic          busy, done;
    logic [3:0]    pos, midx;
    logic [PW-1:0] pow, mpow;
    logic [PW-1:0] sel [LAT];
`ifdef ANT_POW_SCAN_SUM_EN
    logic [PW+3:0] spow;
`endif

    ant_pow_scan #(.PW(PW), .MUX_LAT(LAT)) u_dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .ant_posinfo(pos),
      .ant_pow(pow), .done(done), .max_pow(mpow), .max_idx(midx)
`ifdef ANT_POW_SCAN_SUM_EN
      , .sum_pow(spow)
`endif
    );

    // Registered selector with LAT cycles of latency.
    always @(posedge clk) begin
      sel[0] <= pow_tab[pos];
      for (int i = 1; i < LAT; i++) sel[i] <= sel[i-1];
    end
    assign pow = sel[LAT-1];

    assign busy_v[g] = busy;
    assign done_v[g] = done;
    assign pos_v[g]  = pos;
    assign midx_v[g] = midx;
    assign mpow_v[g] = mpow;
`ifdef ANT_POW_SCAN_SUM_EN
    assign sum_v[g]  = spow;
`else
    assign sum_v[g]  = '0;
`endif
  end

  // ---------------- reference model (scan-level) ----------------
  int            cyc = 0;
  int            epoch = 0;
  bit            primed = 1'b0;
  bit            act [NL];
  int            tst [NL];
  exp_t          cur [NL];
  logic [PW-1:0] hold_mx [NL];
  logic [3:0]    hold_ix [NL];
  logic [PW+3:0] hold_sm [NL];
  bit            e_busy [NL], e_done [NL];
  logic [3:0]    e_pos [NL];
  exp_t          sbq [$];

  function automatic int lat_of(int g);
    return (g == 0) ? 1 : 3;
  endfunction

  function automatic exp_t ref_scan(int g, int t, int ep);
    exp_t e;
    e.lane  = g;
    e.epoch = ep;
    e.tdone = t + 17 + lat_of(g);
    e.mx    = pow_tab[0];
    e.ix    = 4'd0;
    e.sm    = '0;
    for (int k = 0; k < 16; k++) begin
      e.sm = e.sm + {4'b0, pow_tab[k]};
      if (pow_tab[k] > e.mx) begin
        e.mx = pow_tab[k];
        e.ix = 4'(k);
      end
    end
    return e;
  endfunction

  always @(posedge clk) begin
    bit   a;
    int   t;
    exp_t ne;
    if (rst) begin
      primed <= 1'b1;
      epoch  <= epoch + 1;
      for (int g = 0; g < NL; g++) begin
        act[g]     <= 1'b0;
        hold_mx[g] <= '0;
        hold_ix[g] <= '0;
        hold_sm[g] <= '0;
        e_busy[g]  <= 1'b0;
        e_done[g]  <= 1'b0;
        e_pos[g]   <= '0;
      end
    end else begin
      for (int g = 0; g < NL; g++) begin
        a = act[g];
        t = tst[g];
        if (a && cyc == t + 17 + lat_of(g)) begin
          a = 1'b0;
          hold_mx[g] <= cur[g].mx;
          hold_ix[g] <= cur[g].ix;
          hold_sm[g] <= cur[g].sm;
        end else if (!a && start) begin
          a  = 1'b1;
          t  = cyc;
          ne = ref_scan(g, cyc, epoch);
          cur[g] <= ne;
          sbq.push_back(ne);
        end
        act[g]    <= a;
        tst[g]    <= t;
        e_busy[g] <= a && (cyc + 1 <= t + 16 + lat_of(g));
        e_done[g] <= a && (cyc + 1 == t + 17 + lat_of(g));
        e_pos[g]  <= (a && cyc + 1 >= t + 1 && cyc + 1 <= t + 16) ? 4'(cyc - t) : 4'd0;
      end
    end
    cyc <= cyc + 1;
  end

  // ---------------- monitor / scoreboard ----------------
  int total = 0;
  int bad   = 0;
  int tmo   = 0;
  bit fin = 1'b0, fin_done = 1'b0;
  int rd_l [NL];

  task automatic chk(input string nm, input int ln, input logic [63:0] a_v, input logic [63:0] e_v);
    total++;
    if (a_v !== e_v) begin
      bad++;
      if (bad <= 40)
        $display("FAIL %s lane=%0d cyc=%0d got=%0h want=%0h", nm, ln, cyc, a_v, e_v);
    end
  endtask

  always @(negedge clk) begin
    bit   hit;
    int   left;
    exp_t e;
    if (primed) begin
      for (int g = 0; g < NL; g++) begin
        chk("busy", g, busy_v[g], e_busy[g]);
        chk("posinfo", g, pos_v[g], e_pos[g]);
        chk("done", g, done_v[g], e_done[g]);
        if (done_v[g] === 1'b1) begin
          hit = 1'b0;
          for (int i = rd_l[g]; i < sbq.size(); i++) begin
            if (!hit && sbq[i].lane == g && sbq[i].epoch == epoch) begin
              hit     = 1'b1;
              e       = sbq[i];
              rd_l[g] = i + 1;
            end
          end
          chk("sb_hit", g, hit, 1);
          if (hit) begin
            chk("done_cycle", g, cyc, e.tdone);
            chk("max_pow", g, mpow_v[g], e.mx);
            chk("max_idx", g, midx_v[g], e.ix);
`ifdef ANT_POW_SCAN_SUM_EN
            chk("sum_pow", g, sum_v[g], e.sm);
`endif
          end
        end else begin
          chk("max_pow_hold", g, mpow_v[g], hold_mx[g]);
          chk("max_idx_hold", g, midx_v[g], hold_ix[g]);
`ifdef ANT_POW_SCAN_SUM_EN
          chk("sum_pow_hold", g, sum_v[g], hold_sm[g]);
`endif
        end
      end
    end
    if (fin && !fin_done) begin
      for (int g = 0; g < NL; g++) begin
        left = 0;
        for (int i = rd_l[g]; i < sbq.size(); i++)
          if (sbq[i].lane == g && sbq[i].epoch == epoch) left++;
        chk("sb_left", g, left, 0);
      end
      chk("wait_timeouts", -1, tmo, 0);
      fin_done = 1'b1;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((act[0] || act[1]) && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) tmo++;
  endtask

  task automatic scan();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_idle();
  endtask

  initial begin
    for (int k = 0; k < 16; k++) pow_tab[k] = '0;
    rst = 1'b1;
    start = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    for (int k = 0; k < 16; k++) pow_tab[k] = 32'(k * 16);
    scan();

    for (int k = 0; k < 16; k++) pow_tab[k] = 32'h100;
    pow_tab[7]  = 32'h200;
    pow_tab[12] = 32'h200;
    scan();

    for (int k = 0; k < 16; k++) pow_tab[k] = $urandom;
    start = 1'b1;
    repeat (40) tick();
    start = 1'b0;
    wait_idle();

    for (int k = 0; k < 16; k++) pow_tab[k] = $urandom_range(0, 1000);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (8) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_idle();
    scan();

    for (int k = 0; k < 16; k++) pow_tab[k] = 32'd1;
    pow_tab[5] = 32'hFFFF_FFFF;
    scan();

    for (int k = 0; k < 16; k++) pow_tab[k] = $urandom;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (12) begin
      start = 1'($urandom_range(0, 1));
      tick();
    end
    start = 1'b0;
    wait_idle();

    for (int k = 0; k < 16; k++) pow_tab[k] = 32'hFFFF_FFFF;
    scan();
    for (int k = 0; k < 16; k++) pow_tab[k] = '0;
    scan();

    repeat (15) begin
      if ($urandom_range(0, 1) == 0)
        for (int k = 0; k < 16; k++) pow_tab[k] = $urandom;
      else
        for (int k = 0; k < 16; k++) pow_tab[k] = $urandom_range(0, 3);
      repeat ($urandom_range(0, 3)) tick();
      scan();
    end

    tick();
    fin = 1'b1;
    for (int i = 0; i < 10 && !fin_done; i++) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
